// File: rtl/sum_window_accumulator_if.sv
// Sample-in / window-result-out bundle for sum_window_accumulator.
// master drives samples, clear and out_ready; slave is the accumulator.
interface sum_window_accumulator_if #(
    parameter int unsigned IN_W       = 10,
    parameter int unsigned COUNT_LOG2 = 3
);
    logic                       clear;
    logic                       in_valid;
    logic [IN_W-1:0]            in_data;
    logic                       in_ready;
    logic                       out_valid;
    logic                       out_ready;
    logic [IN_W+COUNT_LOG2-1:0] out_total;
    logic [IN_W-1:0]            out_avg;

    modport master (
        output clear, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_total, out_avg
    );

    modport slave (
        input  clear, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_total, out_avg
    );
endinterface

// File: rtl/sum_window_accumulator.sv
// Sums windows of 2^COUNT_LOG2 accepted samples and presents the total and
// truncated mean through a one-deep valid/ready result buffer.
module sum_window_accumulator #(
    parameter int unsigned IN_W       = 10,
    parameter int unsigned COUNT_LOG2 = 3
) (
    input logic                    clock,
    input logic                    reset,
    sum_window_accumulator_if.slave bus
);
    localparam int unsigned SUM_W = IN_W + COUNT_LOG2;
    localparam int unsigned N     = 1 << COUNT_LOG2;

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                state;
    logic [SUM_W-1:0]      acc;
    logic [COUNT_LOG2-1:0] count;
    logic [SUM_W-1:0]      acc_next_c;
    logic                  accept_c;
    logic                  last_c;

    // Sample can only be taken while accumulating; HOLD back-pressures.
    assign bus.in_ready = (state == ACCUM);
    assign accept_c     = bus.in_valid && (state == ACCUM);
    assign acc_next_c   = acc + SUM_W'(bus.in_data);
    assign last_c       = (count == COUNT_LOG2'(N - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ACCUM;
            acc           <= '0;
            count         <= '0;
            bus.out_valid <= 1'b0;
            bus.out_total <= '0;
            bus.out_avg   <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    // clear wins over a same-cycle sample, which is dropped
                    if (bus.clear) begin
                        acc   <= '0;
                        count <= '0;
                    end else if (accept_c) begin
                        if (last_c) begin
                            bus.out_total <= acc_next_c;
                            bus.out_avg   <= acc_next_c[SUM_W-1:COUNT_LOG2];
                            bus.out_valid <= 1'b1;
                            acc           <= '0;
                            count         <= '0;
                            state         <= HOLD;
                        end else begin
                            acc   <= acc_next_c;
                            count <= count + COUNT_LOG2'(1);
                        end
                    end
                end
                HOLD: begin
                    // result stays put until taken; total/avg keep last values
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_sum_window_accumulator.sv
// Self-checking bench for sum_window_accumulator: directed windows plus
// randomized traffic compared against a sample-queue reference model.
module tb_sum_window_accumulator;
    localparam int unsigned IN_W       = 10;
    localparam int unsigned COUNT_LOG2 = 3;
    localparam int unsigned N          = 1 << COUNT_LOG2;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    // reference model state
    bit          m_hold;
    int unsigned m_total;
    int unsigned m_avg;
    int unsigned win[$];

    sum_window_accumulator_if #(.IN_W(IN_W), .COUNT_LOG2(COUNT_LOG2)) bus ();

    sum_window_accumulator #(.IN_W(IN_W), .COUNT_LOG2(COUNT_LOG2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold  = 1'b0;
        m_total = 0;
        m_avg   = 0;
        win.delete();
    endtask

    task automatic check_all(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready),  m_hold ? 0 : 1);
        check({tag, "_out_valid"}, 32'(bus.out_valid), m_hold ? 1 : 0);
        check({tag, "_out_total"}, 32'(bus.out_total), m_total);
        check({tag, "_out_avg"},   32'(bus.out_avg),   m_avg);
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic cycle(input bit v, input int unsigned d, input bit ordy, input bit clr);
        int unsigned sum;
        bus.in_valid  = v;
        bus.in_data   = IN_W'(d);
        bus.out_ready = ordy;
        bus.clear     = clr;
        @(posedge clock);
        if (m_hold) begin
            if (ordy) m_hold = 1'b0;
        end else if (clr) begin
            win.delete();
        end else if (v) begin
            win.push_back(d);
            if (win.size() == N) begin
                sum = 0;
                foreach (win[i]) sum += win[i];
                m_total = sum;
                m_avg   = sum / N;
                m_hold  = 1'b1;
                win.delete();
            end
        end
        #1;
        check_all("cyc");
    endtask

    task automatic window(input int unsigned val, input bit ordy);
        for (int i = 0; i < int'(N); i++) cycle(1'b1, val, ordy, 1'b0);
    endtask

    // Asynchronous reset pulse placed mid-cycle, away from both edges.
    task automatic async_reset_pulse();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("arst_out_valid", 32'(bus.out_valid), 0);
        check("arst_in_ready",  32'(bus.in_ready),  1);
        check("arst_out_total", 32'(bus.out_total), 0);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all("reset");
        @(negedge clock);
        reset = 1'b0;
        #1;

        // 1..8 back to back, consumer always ready
        for (int i = 1; i <= int'(N); i++) cycle(1'b1, i, 1'b1, 1'b0);
        check("t1_total", 32'(bus.out_total), 36);
        check("t1_avg",   32'(bus.out_avg),   4);
        check("t1_valid", 32'(bus.out_valid), 1);
        cycle(1'b0, 0, 1'b1, 1'b0);
        check("t1_valid_drop", 32'(bus.out_valid), 0);
        check("t1_ready_back", 32'(bus.in_ready),  1);

        // full-scale samples must not wrap
        window(1023, 1'b0);
        check("t2_total", 32'(bus.out_total), 8184);
        check("t2_avg",   32'(bus.out_avg),   1023);
        cycle(1'b0, 0, 1'b1, 1'b0);

        // back-pressure with in_valid held high
        window(3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 500, 1'b0, 1'b0);
            check("t3_hold_total", 32'(bus.out_total), 24);
            check("t3_hold_avg",   32'(bus.out_avg),   3);
            check("t3_hold_ready", 32'(bus.in_ready),  0);
        end
        cycle(1'b1, 500, 1'b1, 1'b0);
        window(1, 1'b1);
        check("t3_next_total", 32'(bus.out_total), 8);

        // clear together with a sample drops the partial window and the sample
        cycle(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 100, 1'b1, 1'b0);
        cycle(1'b1, 100, 1'b1, 1'b1);
        window(10, 1'b1);
        check("t4_total", 32'(bus.out_total), 80);
        check("t4_avg",   32'(bus.out_avg),   10);
        cycle(1'b0, 0, 1'b1, 1'b0);

        // gapped samples then asynchronous reset mid-window
        cycle(1'b1, 5, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        cycle(1'b1, 6, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        cycle(1'b1, 7, 1'b1, 1'b0);
        async_reset_pulse();
        window(2, 1'b1);
        check("t5_total", 32'(bus.out_total), 16);
        check("t5_avg",   32'(bus.out_avg),   2);
        cycle(1'b0, 0, 1'b1, 1'b0);

        // truncating mean
        for (int i = 0; i < int'(N) - 1; i++) cycle(1'b1, 1, 1'b0, 1'b0);
        cycle(1'b1, 2, 1'b0, 1'b0);
        check("t6_total", 32'(bus.out_total), 9);
        check("t6_avg",   32'(bus.out_avg),   1);
        // reset while holding a result loses it
        async_reset_pulse();
        cycle(1'b0, 0, 1'b0, 1'b0);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            bit          v;
            bit          o;
            bit          cl;
            int unsigned d;
            v  = ($urandom_range(0, 3) != 0);
            o  = ($urandom_range(0, 2) != 0);
            cl = ($urandom_range(0, 40) == 0);
            d  = ($urandom_range(0, 7) == 0) ? 1023 : $urandom_range(0, 1023);
            cycle(v, d, o, cl);
            if ($urandom_range(0, 600) == 0) async_reset_pulse();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
